// File: rtl/fifo_dual.sv
// Single-clock FIFO on an inferred dual-port RAM whose registered read port is the output register.
// Handshake: a word moves on an edge only when valid and ready are both high; data holds while valid && !ready.
module fifo_dual #(
  parameter int WIDTH = 8,
  parameter int AW    = 7,
  parameter int AFULL = (1 << AW) - 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      level,
  output logic             almost_full
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AFULL_L = (AW + 1)'(AFULL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      ram_cnt;
  logic [AW:0]      level_next;
  logic             push;
  logic             pop;
  logic             load;

  assign in_ready = (level != DEPTH_L) && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  // Words still in the RAM; a push on this edge is not yet readable.
  assign ram_cnt  = level - {{AW{1'b0}}, out_valid};
  assign load     = (!out_valid || out_ready) && (ram_cnt != '0);

  always_comb begin
    level_next = level;
    if (push && !pop) level_next = level + 1'b1;
    if (pop && !push) level_next = level - 1'b1;
  end

  // RAM array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wp] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp          <= '0;
      rp          <= '0;
      level       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      almost_full <= 1'b0;
    end else if (flush) begin
      wp          <= '0;
      rp          <= '0;
      level       <= '0;
      out_valid   <= 1'b0;
      almost_full <= (AFULL_L == '0);
    end else begin
      if (push) wp <= wp + 1'b1;
      if (load) begin
        out_data  <= mem[rp];
        rp        <= rp + 1'b1;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      level       <= level_next;
      almost_full <= (level_next >= AFULL_L);
    end
  end

endmodule

// File: tb/tb_fifo_dual.sv
// Bench for fifo_dual (AW=3, AFULL=4): vector table, hand sequences and a random run
// against a queue-based reference model.
module tb_fifo_dual;
  localparam int WIDTH = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFULL = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [AW:0]      level;
  logic             almost_full;

  fifo_dual #(.WIDTH(WIDTH), .AW(AW), .AFULL(AFULL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .almost_full(almost_full)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: exp_q holds every stored word in order, m_ov says the head is visible
  logic [WIDTH-1:0] exp_q[$];
  bit               m_ov = 1'b0;
  logic [WIDTH-1:0] got_q[$];

  typedef struct {
    logic             fl;
    logic             iv;
    logic [WIDTH-1:0] id;
    logic             ordy;
    logic             ev;
    logic [WIDTH-1:0] ed;
    logic [AW:0]      el;
    logic             er;
    logic             ea;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic fl, input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
    int  sz;
    int  ram;
    bit  do_push;
    bit  do_pop;
    sz      = exp_q.size();
    ram     = sz - int'(m_ov);
    do_push = iv && (sz != DEPTH);
    do_pop  = m_ov && ordy;
    if (fl) begin
      exp_q.delete();
      m_ov = 1'b0;
    end else begin
      if (do_pop) got_q.push_back(exp_q.pop_front());
      if (do_push) exp_q.push_back(id);
      if (ram > 0) m_ov = 1'b1;
      else if (do_pop) m_ov = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) chk("out_data", 32'(out_data), 32'(exp_q[0]));
    chk("level", 32'(level), 32'(exp_q.size()));
    chk("almost_full", 32'(almost_full), 32'(exp_q.size() >= AFULL));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
  endtask

  // driver: called just after a falling edge; drives, clocks, checks #1 after the rising edge
  task automatic step(input logic fl, input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    model_edge(fl, iv, id, ordy);
    @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
  endtask

  function automatic void add_vec(input logic fl, input logic iv, input logic [WIDTH-1:0] id,
                                  input logic ordy, input logic ev, input logic [WIDTH-1:0] ed,
                                  input logic [AW:0] el, input logic er, input logic ea);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.el = el; v.er = er; v.ea = ea;
    vecs.push_back(v);
  endfunction

  initial begin
    // table: latency, hold, fill to full, refused offer, pop at full, flush collision, restart
    add_vec(0, 1, 8'hA5, 0, 0, 8'h00, 1, 1, 0);
    for (int i = 0; i < 5; i++) add_vec(0, 0, 8'h00, 0, 1, 8'hA5, 1, 1, 0);
    add_vec(0, 1, 8'h01, 0, 1, 8'hA5, 2, 1, 0);
    add_vec(0, 1, 8'h02, 0, 1, 8'hA5, 3, 1, 0);
    add_vec(0, 1, 8'h03, 0, 1, 8'hA5, 4, 1, 1);
    add_vec(0, 1, 8'h04, 0, 1, 8'hA5, 5, 1, 1);
    add_vec(0, 1, 8'h05, 0, 1, 8'hA5, 6, 1, 1);
    add_vec(0, 1, 8'h06, 0, 1, 8'hA5, 7, 1, 1);
    add_vec(0, 1, 8'h07, 0, 1, 8'hA5, 8, 0, 1);
    add_vec(0, 1, 8'h08, 0, 1, 8'hA5, 8, 0, 1);
    add_vec(0, 0, 8'h00, 1, 1, 8'h01, 7, 1, 1);
    add_vec(0, 1, 8'h09, 1, 1, 8'h02, 7, 1, 1);
    add_vec(1, 1, 8'h55, 1, 0, 8'h00, 0, 1, 0);
    add_vec(0, 1, 8'h3C, 0, 0, 8'h00, 1, 1, 0);
    add_vec(0, 0, 8'h00, 0, 1, 8'h3C, 1, 1, 0);

    // reset state
    #1;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data", 32'(out_data), 0);
    chk("rst level", 32'(level), 0);
    chk("rst almost_full", 32'(almost_full), 0);
    chk("rst in_ready", 32'(in_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release in_ready", 32'(in_ready), 1);
    @(negedge clk);

    foreach (vecs[i]) begin
      step(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      if (vecs[i].ev) chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].ed));
      chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].el));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].er));
      chk($sformatf("vec%0d almost_full", i), 32'(almost_full), 32'(vecs[i].ea));
    end

    // flush collision at level 5
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h10 + i), 0);
    chk("pre-flush level", 32'(level), 5);
    step(1, 1, 8'h77, 1);
    chk("flush level", 32'(level), 0);
    chk("flush out_valid", 32'(out_valid), 0);
    step(0, 1, 8'h3C, 0);
    step(0, 0, 0, 0);
    chk("post-flush head", 32'(out_data), 32'h3C);

    // streaming wrap: 0..99 with continuous push and pop
    step(1, 0, 0, 0);
    got_q.delete();
    for (int i = 0; i < 100; i++) step(0, 1, 8'(i), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    chk("stream count", 32'(got_q.size()), 100);
    for (int i = 0; i < 100 && i < got_q.size(); i++) chk("stream order", 32'(got_q[i]), 32'(i));

    // reset mid-burst
    for (int i = 0; i < 3; i++) step(0, 1, 8'(8'hE0 + i), 0);
    rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(out_valid), 0);
    chk("midrst level", 32'(level), 0);
    chk("midrst in_ready", 32'(in_ready), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_ov = 1'b0;
    in_valid = 1'b0;
    step(0, 0, 0, 1);
    chk("after rst in_ready", 32'(in_ready), 1);

    // random backpressure
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 60),
           8'($urandom_range(0, 255)), ($urandom_range(0, 99) < 50));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
